// File: rtl/sdram_fill_pkg.sv
// Shared types and LFSR helpers for the SDRAM fill write master.
package sdram_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  // Fibonacci taps 16,14,13,11 expressed as the shifted-out bit positions 0,2,3,5
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] d);
    return {^(d & LFSR_TAP_MASK), d[15:1]};
  endfunction

endpackage

// File: rtl/sdram_fill_master_if.sv
// Avalon-MM write-only bus between the fill master and the SDRAM controller slave.
interface sdram_fill_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   address;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;

  modport master (
    output address, write, writedata, byteenable,
    input  waitrequest
  );

  modport slave (
    input  address, write, writedata, byteenable,
    output waitrequest
  );
endinterface

// File: rtl/sdram_fill_pattern_gen.sv
// Fill pattern source: 16-bit Fibonacci LFSR, or an incrementing ramp when
// SDRAM_FILL_RAMP_EN is defined.
module sdram_fill_pattern_gen
  import sdram_fill_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] data
);

`ifdef SDRAM_FILL_RAMP_EN
  always_ff @(posedge clk) begin
    if (reset)     data <= '0;
    else if (load) data <= seed;
    else if (step) data <= data + DATA_W'(1);
  end
`else
  // An all-zero seed would lock the LFSR, so it is replaced by the default seed
  always_ff @(posedge clk) begin
    if (reset)     data <= '0;
    else if (load) data <= (seed == '0) ? DATA_W'(LFSR_DEFAULT_SEED) : seed;
    else if (step) data <= DATA_W'(lfsr_next(16'(data)));
  end
`endif

endmodule

// File: rtl/sdram_fill_master.sv
// Avalon-MM write master filling NUM_WORDS words from BASE_ADDR with a pattern,
// tracking max/min of the data written. SDRAM_FILL_RAMP_EN selects the ramp pattern.
module sdram_fill_master
  import sdram_fill_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              NUM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready_in,
  input  logic [DATA_W-1:0] seed_in,
  output logic              done_out,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  sdram_fill_master_if.master avm
);

  localparam int               IDX_W     = $clog2(NUM_WORDS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  state_t           state, state_nxt;
  logic             start, accept, last;
  logic [IDX_W-1:0] idx;
  logic [DATA_W-1:0] pattern;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ready_in)       state_nxt = WRITE;
      WRITE:   if (accept && last) state_nxt = DONE;
      DONE:    if (!ready_in)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start  = (state == IDLE) && ready_in;
    accept = (state == WRITE) && avm.write && !avm.waitrequest;
    last   = (idx == LAST_IDX);
  end

  // Bus, counter and statistics registers; all hold while the slave stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      avm.write   <= 1'b0;
      avm.address <= BASE_ADDR;
      idx         <= '0;
      done_out    <= 1'b0;
      max_out     <= '0;
      min_out     <= '1;
    end else begin
      if (start) begin
        avm.write   <= 1'b1;
        avm.address <= BASE_ADDR;
        idx         <= '0;
        max_out     <= '0;
        min_out     <= '1;
      end
      if (accept) begin
        if (avm.writedata > max_out) max_out <= avm.writedata;
        if (avm.writedata < min_out) min_out <= avm.writedata;
        idx         <= idx + IDX_W'(1);
        avm.address <= avm.address + ADDR_STEP;
        if (last) begin
          avm.write <= 1'b0;
          done_out  <= 1'b1;
        end
      end
      if ((state == DONE) && !ready_in) done_out <= 1'b0;
    end
  end

  sdram_fill_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .step  (accept),
    .seed  (seed_in),
    .data  (pattern)
  );

  assign avm.writedata  = pattern;
  assign avm.byteenable = '1;

endmodule

// File: tb/tb_sdram_fill_master.sv
// Scoreboard bench for sdram_fill_master with NUM_WORDS=4; stimulus pushes expected
// writes, a negedge monitor drives waitrequest and checks every presented write.
module tb_sdram_fill_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [15:0] seed;
  logic        done;
  logic [15:0] mx_o, mn_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic [47:0] exp_q[$];
  int acc_total    = 0;
  int stall_target = -1;
  int stall_len    = 0;

  sdram_fill_master_if #(.ADDR_W(32), .DATA_W(16)) avm ();

  sdram_fill_master #(
    .ADDR_W(32), .DATA_W(16), .BASE_ADDR(32'h0), .NUM_WORDS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ready_in (ready),
    .seed_in  (seed),
    .done_out (done),
    .max_out  (mx_o),
    .min_out  (mn_o),
    .avm      (avm)
  );

  always #5 clk = ~clk;

`ifdef SDRAM_FILL_RAMP_EN
  logic [15:0] wtab [3][4] = '{'{16'hACE1, 16'hACE2, 16'hACE3, 16'hACE4},
                               '{16'h0000, 16'h0001, 16'h0002, 16'h0003},
                               '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001}};
  logic [15:0] mxtab [3] = '{16'hACE4, 16'h0003, 16'hFFFF};
  logic [15:0] mntab [3] = '{16'hACE1, 16'h0000, 16'h0000};
`else
  logic [15:0] wtab [3][4] = '{'{16'hACE1, 16'h5670, 16'hAB38, 16'h559C},
                               '{16'hACE1, 16'h5670, 16'hAB38, 16'h559C},
                               '{16'hFFFE, 16'hFFFF, 16'h7FFF, 16'h3FFF}};
  logic [15:0] mxtab [3] = '{16'hACE1, 16'hACE1, 16'hFFFF};
  logic [15:0] mntab [3] = '{16'h559C, 16'h559C, 16'h3FFF};
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: decides waitrequest for the coming edge, then scores the presented write
  initial begin : monitor
    int stall_cnt  = 0;
    int stall_seen = -1;
    avm.waitrequest = 1'b0;
    forever begin
      @(negedge clk);
      if (acc_total != stall_seen) begin
        stall_cnt  = 0;
        stall_seen = acc_total;
      end
      if (avm.write && acc_total == stall_target && stall_cnt < stall_len) begin
        avm.waitrequest = 1'b1;
        stall_cnt++;
      end else begin
        avm.waitrequest = 1'b0;
      end
      if (avm.write) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h with empty scoreboard",
                   avm.address, avm.writedata);
        end else begin
          chk("wr_addr", avm.address, exp_q[0][47:16]);
          chk("wr_data", 32'(avm.writedata), 32'(exp_q[0][15:0]));
          chk("wr_be", 32'(avm.byteenable), 32'h3);
          if (!avm.waitrequest) begin
            void'(exp_q.pop_front());
            acc_total++;
          end
        end
      end
    end
  end

  task automatic run(input int sel, input logic [15:0] s, input int stall_w,
                     input int stall_l, input bit drop_early);
    int base;
    int lat;
    @(negedge clk);
    base         = acc_total;
    stall_target = (stall_w < 0) ? -1 : base + stall_w;
    stall_len    = stall_l;
    for (int i = 0; i < 4; i++) exp_q.push_back({32'(2 * i), wtab[sel][i]});
    seed  = s;
    ready = 1'b1;
    lat   = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("start_max_cleared", 32'(mx_o), 32'h0000);
        chk("start_min_cleared", 32'(mn_o), 32'hFFFF);
        if (drop_early) ready = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", lat, 5 + stall_l);
    chk("words_written", acc_total - base, 4);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("max_out", 32'(mx_o), 32'(mxtab[sel]));
    chk("min_out", 32'(mn_o), 32'(mntab[sel]));
    if (!drop_early) begin
      repeat (4) @(negedge clk);
      chk("done_held", 32'(done), 1);
      chk("no_retrigger_write", 32'(avm.write), 0);
      chk("no_retrigger_count", acc_total - base, 4);
      ready = 1'b0;
    end
    @(negedge clk);
    chk("done_cleared", 32'(done), 0);
    stall_target = -1;
  endtask

  initial begin : stim
    int base;
    reset = 1'b1;
    ready = 1'b0;
    seed  = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 0);
    chk("rst_write", 32'(avm.write), 0);
    chk("rst_addr", avm.address, 32'h0);
    chk("rst_wdata", 32'(avm.writedata), 0);
    chk("rst_be", 32'(avm.byteenable), 32'h3);
    chk("rst_max", 32'(mx_o), 32'h0000);
    chk("rst_min", 32'(mn_o), 32'hFFFF);
    reset = 1'b0;
    @(negedge clk);

    run(0, 16'hACE1, -1, 0, 1'b0);
    run(0, 16'hACE1,  1, 3, 1'b0);
    run(1, 16'h0000, -1, 0, 1'b0);
    run(2, 16'hFFFE, -1, 0, 1'b0);
    run(0, 16'hACE1, -1, 0, 1'b1);

    // Reset while word 2 is stalled on the bus
    @(negedge clk);
    base         = acc_total;
    stall_target = base + 2;
    stall_len    = 1000;
    for (int i = 0; i < 3; i++) exp_q.push_back({32'(2 * i), wtab[0][i]});
    seed  = 16'hACE1;
    ready = 1'b1;
    for (int k = 0; k < 50 && acc_total != base + 2; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("midrun_stalled", 32'(avm.write), 1);
    reset = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    chk("midrun_rst_write", 32'(avm.write), 0);
    chk("midrun_rst_done", 32'(done), 0);
    chk("midrun_rst_addr", avm.address, 32'h0);
    chk("midrun_rst_max", 32'(mx_o), 32'h0000);
    chk("midrun_rst_min", 32'(mn_o), 32'hFFFF);
    @(negedge clk);
    chk("midrun_words", acc_total - base, 2);
    reset        = 1'b0;
    stall_target = -1;
    exp_q.delete();

    run(0, 16'hACE1, -1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
